// File: rtl/fwd_pkg.sv
// Shared types and constants for the decode-stage forwarding scoreboard.
// Entry struct is sized for the widest supported register address and latency.
package fwd_pkg;

  localparam int MAX_AW       = 8;
  localparam int LAT_W        = 6;
  localparam int SRC_RF       = 0;
  localparam int DEF_ALU_LAT  = 1;
  localparam int DEF_LOAD_LAT = 2;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] rd;
    logic [LAT_W-1:0]  lat;
  } fwd_entry_t;

  // Encodes 0 (register file) plus stages 1..depth.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// One read port's youngest-first match over all in-flight entries; combinational, no latency.
// A younger not-yet-ready producer stalls even when an older ready one exists.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int SELW   = 2
) (
  input  fwd_entry_t [DEPTH-1:0] ent_i,
  input  logic [REG_AW-1:0]      addr_i,
  input  logic                   used_i,
  output logic [SELW-1:0]        sel_o,
  output logic                   stall_o
);

  logic [MAX_AW-1:0] addr_ext;
  logic              active;

  assign addr_ext = MAX_AW'(addr_i);
  assign active   = used_i && (addr_i != '0);

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    sel_o   = SELW'(SRC_RF);
    stall_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (active && ent_i[k].valid && (ent_i[k].rd == addr_ext)) begin
        if ((k + 1) >= int'(ent_i[k].lat)) begin
          sel_o   = SELW'(k + 1);
          stall_o = 1'b0;
        end else begin
          sel_o   = SELW'(SRC_RF);
          stall_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: per-port source select and load-use stall, combinational from state.
// Entries shift every cycle; a stall or flush inserts a bubble at stage 1 instead of freezing.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_RD   = 2,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  localparam int SELW    = sel_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [REG_AW-1:0]        issue_rd,
  input  logic                     issue_regwrite,
  input  logic                     issue_is_load,
  input  logic                     flush,
  input  logic [NUM_RD*REG_AW-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_used,
  output logic [NUM_RD*SELW-1:0]   fwd_sel,
  output logic                     stall,
  output logic                     busy,
  output logic [15:0]              stall_cnt
);

  fwd_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [NUM_RD-1:0]      port_stall;
  logic                   recordable;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_match #(
      .DEPTH (DEPTH),
      .REG_AW(REG_AW),
      .SELW  (SELW)
    ) u_match (
      .ent_i  (ent_q),
      .addr_i (rd_addr[p*REG_AW +: REG_AW]),
      .used_i (rd_used[p]),
      .sel_o  (fwd_sel[p*SELW +: SELW]),
      .stall_o(port_stall[p])
    );
  end

  assign stall      = (|port_stall) && issue_valid && !flush;
  assign recordable = issue_valid && issue_regwrite && (issue_rd != '0);

  always_comb begin
    ent_d = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      ent_d[k] = ent_q[k-1];
    end
    if (recordable && !stall && !flush) begin
      ent_d[0].valid = 1'b1;
      ent_d[0].rd    = MAX_AW'(issue_rd);
      ent_d[0].lat   = issue_is_load ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
    end
  end

  assign cnt_d = (stall && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      busy = busy | ent_q[k].valid;
    end
  end

  assign stall_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a default-parameter instance plus a deep instance
// whose long load latency lets the stall counter reach saturation within the cycle budget.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_regwrite, issue_is_load, flush;
  logic [4:0]  issue_rd;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_used;
  logic [3:0]  fwd_sel;
  logic        stall, busy;
  logic [15:0] stall_cnt;

  logic        s_rst;
  logic [9:0]  s_rd_addr;
  logic [9:0]  s_fwd_sel;
  logic        s_stall, s_busy;
  logic [15:0] s_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.NUM_RD(2), .REG_AW(5), .DEPTH(3), .ALU_LAT(1), .LOAD_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_regwrite(issue_regwrite),
    .issue_is_load(issue_is_load), .flush(flush),
    .rd_addr(rd_addr), .rd_used(rd_used),
    .fwd_sel(fwd_sel), .stall(stall), .busy(busy), .stall_cnt(stall_cnt)
  );

  fwd_scoreboard #(.NUM_RD(2), .REG_AW(5), .DEPTH(31), .ALU_LAT(1), .LOAD_LAT(31)) u_sat (
    .clk(clk), .rst(s_rst),
    .issue_valid(1'b1), .issue_rd(5'd3), .issue_regwrite(1'b1),
    .issue_is_load(1'b1), .flush(1'b0),
    .rd_addr(s_rd_addr), .rd_used(2'b01),
    .fwd_sel(s_fwd_sel), .stall(s_stall), .busy(s_busy), .stall_cnt(s_stall_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic rw, input logic ld);
    issue_valid    = v;
    issue_rd       = rd;
    issue_regwrite = rw;
    issue_is_load  = ld;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
    rd_addr = {a1, a0};
    rd_used = used;
  endtask

  task automatic idle(input int n);
    set_issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_rd(5'd0, 5'd0, 2'b00);
    repeat (n) tick();
  endtask

  initial begin
    rst   = 1'b1;
    s_rst = 1'b1;
    s_rd_addr = {5'd0, 5'd3};
    flush = 1'b0;
    set_issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_rd(5'd3, 5'd5, 2'b11);
    #3;
    check_val("rst_sel",   32'(fwd_sel),   32'h0);
    check_val("rst_stall", 32'(stall),     32'h0);
    check_val("rst_busy",  32'(busy),      32'h0);
    check_val("rst_cnt",   32'(stall_cnt), 32'h0);
    tick();
    rst = 1'b0;

    // ALU producer r5 forwarded from stage 1, then 2, then 3
    set_issue(1'b1, 5'd5, 1'b1, 1'b0);
    set_rd(5'd0, 5'd0, 2'b00);
    tick();
    set_issue(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd5, 5'd0, 2'b01);
    settle();
    check_val("alu_s1_sel",   32'(fwd_sel[1:0]), 32'd1);
    check_val("alu_s1_stall", 32'(stall),        32'd0);
    check_val("alu_s1_busy",  32'(busy),         32'd1);
    tick();
    settle();
    check_val("alu_s2_sel", 32'(fwd_sel[1:0]), 32'd2);
    tick();
    settle();
    check_val("alu_s3_sel", 32'(fwd_sel[1:0]), 32'd3);
    idle(1);
    settle();
    check_val("alu_drained", 32'(busy), 32'd0);

    // Load-use on port 1: one stall cycle then forward from stage 2
    set_issue(1'b1, 5'd7, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd0, 5'd7, 2'b10);
    settle();
    check_val("ld_stall", 32'(stall), 32'd1);
    tick();
    settle();
    check_val("ld_cnt",      32'(stall_cnt),    32'd1);
    check_val("ld_sel",      32'(fwd_sel[3:2]), 32'd2);
    check_val("ld_nostall",  32'(stall),        32'd0);
    idle(3);

    // Youngest producer (load r4) wins over older ready ALU r4
    set_issue(1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 5'd4, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd4, 5'd0, 2'b01);
    settle();
    check_val("young_stall", 32'(stall), 32'd1);
    tick();
    settle();
    check_val("young_sel", 32'(fwd_sel[1:0]), 32'd2);
    check_val("young_cnt", 32'(stall_cnt),    32'd2);
    idle(3);

    // r0 never recorded or matched; a self-read does not see its own write
    set_issue(1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 5'd9, 1'b1, 1'b0);
    set_rd(5'd0, 5'd9, 2'b11);
    settle();
    check_val("r0_busy",   32'(busy),    32'd0);
    check_val("self_sel",  32'(fwd_sel), 32'd0);
    check_val("self_stall",32'(stall),   32'd0);
    tick();
    set_issue(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd9, 5'd9, 2'b00);
    settle();
    check_val("unused_sel",   32'(fwd_sel), 32'd0);
    check_val("unused_stall", 32'(stall),   32'd0);
    idle(3);

    // Flush on a load-use cycle: no stall, no count, decode write r8 dropped
    set_issue(1'b1, 5'd6, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 5'd8, 1'b1, 1'b0);
    flush = 1'b1;
    set_rd(5'd6, 5'd0, 2'b01);
    settle();
    check_val("flush_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    set_issue(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd0, 5'd8, 2'b10);
    settle();
    check_val("flush_e1_sel", 32'(fwd_sel[3:2]), 32'd0);
    check_val("flush_cnt",    32'(stall_cnt),    32'd2);
    idle(3);

    // Async reset in the middle of a stall
    set_issue(1'b1, 5'd7, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd0, 5'd7, 2'b10);
    settle();
    check_val("mid_pre_stall", 32'(stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_stall", 32'(stall),     32'd0);
    check_val("mid_rst_busy",  32'(busy),      32'd0);
    check_val("mid_rst_cnt",   32'(stall_cnt), 32'd0);
    check_val("mid_rst_sel",   32'(fwd_sel),   32'd0);
    #1 rst = 1'b0;
    set_issue(1'b1, 5'd2, 1'b1, 1'b0);
    set_rd(5'd0, 5'd0, 2'b00);
    tick();
    set_issue(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd2, 5'd0, 2'b01);
    settle();
    check_val("post_rst_sel",  32'(fwd_sel[1:0]), 32'd1);
    check_val("post_rst_busy", 32'(busy),         32'd1);
    idle(3);

    // Saturation: 30 stall cycles per 31-cycle period on the deep instance
    s_rst = 1'b0;
    repeat (68200) @(posedge clk);
    #3;
    check_val("sat_cnt", 32'(s_stall_cnt), 32'hFFFF);
    check_val("sat_busy", 32'(s_busy), 32'd1);
    repeat (100) @(posedge clk);
    #3;
    check_val("sat_hold", 32'(s_stall_cnt), 32'hFFFF);
    s_rst = 1'b1;
    #1;
    check_val("sat_rst_cnt",   32'(s_stall_cnt), 32'h0);
    check_val("sat_rst_busy",  32'(s_busy),      32'h0);
    check_val("sat_rst_stall", 32'(s_stall),     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
